// File: rtl/bot_state_server.sv
// bot_state_server
//
// Hardware stand-in for the integrator's file-driven state reader and
// velocity writer. Keeps an N_BOTS-entry table of {x, y, vx, vy} in signed
// Q5.11. Serves bot pairs (i, j), i < j, in fixed round-robin order on each
// fetch request. Stores the post-collision velocities that come back on the
// output_check handshake.
//
// Optional feature macro: BOT_SERVER_VCLAMP_EN
//   defined   : written-back velocities are saturated to [-VMAX, +VMAX]
//               (the VMAX parameter exists only in this build)
//   undefined : velocities are stored verbatim; no clamp logic
//
// Ports
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   en                   fetch request level, sampled only while idle
//   x, y, vx, vy         state of bot i of the presented pair
//   x2, y2, vx2, vy2     state of bot j of the presented pair
//   input_check          one-cycle pulse: pair outputs are valid
//   output_check         write-back strobe (its rising edge is used)
//   wb_vx1 .. wb_vy2     new velocities for bot i and bot j
//   ld_valid, ld_idx     preload strobe and bot index
//   ld_data              preload record {x, y, vx, vy}, x in the MSBs
//   busy                 high whenever the FSM is not idle
//   round_done           one-cycle pulse after the last pair of a round commits
module bot_state_server #(
    parameter int N_BOTS = 4,
    parameter int W      = 16
`ifdef BOT_SERVER_VCLAMP_EN
    ,
    parameter logic signed [W-1:0] VMAX = 16'sd4096
`endif
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      en,
    output logic [W-1:0]              x,
    output logic [W-1:0]              y,
    output logic [W-1:0]              vx,
    output logic [W-1:0]              vy,
    output logic [W-1:0]              x2,
    output logic [W-1:0]              y2,
    output logic [W-1:0]              vx2,
    output logic [W-1:0]              vy2,
    output logic                      input_check,
    input  logic                      output_check,
    input  logic [W-1:0]              wb_vx1,
    input  logic [W-1:0]              wb_vy1,
    input  logic [W-1:0]              wb_vx2,
    input  logic [W-1:0]              wb_vy2,
    input  logic                      ld_valid,
    input  logic [$clog2(N_BOTS)-1:0] ld_idx,
    input  logic [4*W-1:0]            ld_data,
    output logic                      busy,
    output logic                      round_done
);

    localparam int IDX_W = $clog2(N_BOTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_PRESENT,
        S_WAIT_WB,
        S_COMMIT
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_i;
    logic [IDX_W-1:0]      r_j;
    logic                  r_oc_prev;
    logic                  r_input_check;
    logic                  r_busy;
    logic                  r_round_done;

    logic signed [W-1:0]   r_x,  r_y,  r_vx,  r_vy;
    logic signed [W-1:0]   r_x2, r_y2, r_vx2, r_vy2;

    logic signed [W-1:0]   r_wb_vx1, r_wb_vy1, r_wb_vx2, r_wb_vy2;

    logic signed [W-1:0]   r_mem_x  [N_BOTS];
    logic signed [W-1:0]   r_mem_y  [N_BOTS];
    logic signed [W-1:0]   r_mem_vx [N_BOTS];
    logic signed [W-1:0]   r_mem_vy [N_BOTS];

    logic                  w_oc_rise;
    logic                  w_commit;
    logic                  w_last_pair;

    // Velocity conditioning applied on the way into the table.
    function automatic logic signed [W-1:0] f_wb_vel(input logic signed [W-1:0] v);
`ifdef BOT_SERVER_VCLAMP_EN
        if (v > VMAX) begin
            return VMAX;
        end else if (v < -VMAX) begin
            return -VMAX;
        end else begin
            return v;
        end
`else
        return v;
`endif
    endfunction

    // The edge detector samples every cycle, so a strobe that is already
    // high when WAIT_WB is entered has r_oc_prev = 1 and is not an edge.
    assign w_oc_rise   = output_check & ~r_oc_prev;
    assign w_commit    = (r_state == S_COMMIT);
    assign w_last_pair = (r_i == IDX_W'(N_BOTS - 2)) && (r_j == IDX_W'(N_BOTS - 1));

    assign x           = r_x;
    assign y           = r_y;
    assign vx          = r_vx;
    assign vy          = r_vy;
    assign x2          = r_x2;
    assign y2          = r_y2;
    assign vx2         = r_vx2;
    assign vy2         = r_vy2;
    assign input_check = r_input_check;
    assign busy        = r_busy;
    assign round_done  = r_round_done;

    // Control FSM, pair counter and registered pair outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_i           <= '0;
            r_j           <= IDX_W'(1);
            r_oc_prev     <= 1'b0;
            r_input_check <= 1'b0;
            r_busy        <= 1'b0;
            r_round_done  <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_vx          <= '0;
            r_vy          <= '0;
            r_x2          <= '0;
            r_y2          <= '0;
            r_vx2         <= '0;
            r_vy2         <= '0;
        end else begin
            r_oc_prev     <= output_check;
            r_input_check <= 1'b0;
            r_round_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state <= S_RD_A;
                        r_busy  <= 1'b1;
                    end
                end
                S_RD_A: begin
                    r_x     <= r_mem_x[r_i];
                    r_y     <= r_mem_y[r_i];
                    r_vx    <= r_mem_vx[r_i];
                    r_vy    <= r_mem_vy[r_i];
                    r_state <= S_RD_B;
                end
                S_RD_B: begin
                    r_x2    <= r_mem_x[r_j];
                    r_y2    <= r_mem_y[r_j];
                    r_vx2   <= r_mem_vx[r_j];
                    r_vy2   <= r_mem_vy[r_j];
                    r_state <= S_PRESENT;
                end
                S_PRESENT: begin
                    r_input_check <= 1'b1;
                    r_state       <= S_WAIT_WB;
                end
                S_WAIT_WB: begin
                    if (w_oc_rise) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    // (i, j) walk: bump j; when j hits the end, bump i and
                    // restart j just above it; after (N-2, N-1) wrap to (0, 1).
                    if (r_j == IDX_W'(N_BOTS - 1)) begin
                        if (w_last_pair) begin
                            r_i <= '0;
                            r_j <= IDX_W'(1);
                        end else begin
                            r_i <= r_i + IDX_W'(1);
                            r_j <= r_i + IDX_W'(2);
                        end
                    end else begin
                        r_j <= r_j + IDX_W'(1);
                    end
                    r_round_done <= w_last_pair;
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Write-back capture: data only, qualified by the FSM so a reset simply
    // leaves a stale value that is never committed.
    always_ff @(posedge clock) begin
        if (r_state == S_WAIT_WB && w_oc_rise) begin
            r_wb_vx1 <= wb_vx1;
            r_wb_vy1 <= wb_vy1;
            r_wb_vx2 <= wb_vx2;
            r_wb_vy2 <= wb_vy2;
        end
    end

    // Bot table: preload writes the full record; a same-cycle commit to the
    // same bot is written later in the block so its velocity wins while the
    // preload position still lands. Indices >= N_BOTS never match any entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < N_BOTS; b++) begin
                r_mem_x[b]  <= '0;
                r_mem_y[b]  <= '0;
                r_mem_vx[b] <= '0;
                r_mem_vy[b] <= '0;
            end
        end else begin
            for (int b = 0; b < N_BOTS; b++) begin
                if (ld_valid && (ld_idx == IDX_W'(b))) begin
                    r_mem_x[b]  <= ld_data[4*W-1 -: W];
                    r_mem_y[b]  <= ld_data[3*W-1 -: W];
                    r_mem_vx[b] <= ld_data[2*W-1 -: W];
                    r_mem_vy[b] <= ld_data[W-1:0];
                end
                if (w_commit && (r_i == IDX_W'(b))) begin
                    r_mem_vx[b] <= f_wb_vel(r_wb_vx1);
                    r_mem_vy[b] <= f_wb_vel(r_wb_vy1);
                end
                if (w_commit && (r_j == IDX_W'(b))) begin
                    r_mem_vx[b] <= f_wb_vel(r_wb_vx2);
                    r_mem_vy[b] <= f_wb_vel(r_wb_vy2);
                end
            end
        end
    end

endmodule

// File: tb/tb_bot_state_server.sv
module tb_bot_state_server;

    localparam int NB = 4;
    localparam int W  = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          en;
    logic [W-1:0]  x, y, vx, vy, x2, y2, vx2, vy2;
    logic          input_check;
    logic          output_check;
    logic [W-1:0]  wb_vx1, wb_vy1, wb_vx2, wb_vy2;
    logic          ld_valid;
    logic [1:0]    ld_idx;
    logic [4*W-1:0] ld_data;
    logic          busy;
    logic          round_done;

    bot_state_server #(.N_BOTS(NB), .W(W)) dut (
        .clock(clock), .reset(reset), .en(en),
        .x(x), .y(y), .vx(vx), .vy(vy),
        .x2(x2), .y2(y2), .vx2(vx2), .vy2(vy2),
        .input_check(input_check), .output_check(output_check),
        .wb_vx1(wb_vx1), .wb_vy1(wb_vy1), .wb_vx2(wb_vx2), .wb_vy2(wb_vy2),
        .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data),
        .busy(busy), .round_done(round_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] x, y, vx, vy, x2, y2, vx2, vy2;
    } pair_t;

    typedef struct {
        logic [W-1:0] wvx1, wvy1, wvx2, wvy2;
        int           i, j;
        logic         rd;
    } vec_t;

    pair_t        sb_q[$];
    pair_t        last_exp;
    logic [W-1:0] m_x[NB], m_y[NB], m_vx[NB], m_vy[NB];
    int           n_checks = 0;
    int           n_pass   = 0;

    function automatic logic [W-1:0] vclamp(input logic [W-1:0] v);
`ifdef BOT_SERVER_VCLAMP_EN
        logic signed [W-1:0] s;
        s = v;
        if (s > 16'sd4096) return 16'h1000;
        if (s < -16'sd4096) return 16'hF000;
        return v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input int idx, input logic [W-1:0] px, py, pvx, pvy);
        ld_valid = 1'b1;
        ld_idx   = 2'(idx);
        ld_data  = {px, py, pvx, pvy};
        tick();
        ld_valid = 1'b0;
        m_x[idx] = px; m_y[idx] = py; m_vx[idx] = pvx; m_vy[idx] = pvy;
    endtask

    // Push the expected pair, request a fetch, wait (bounded) for the pulse.
    task automatic start_fetch(input int i, input int j);
        pair_t e;
        int    lat;
        e = '{m_x[i], m_y[i], m_vx[i], m_vy[i], m_x[j], m_y[j], m_vx[j], m_vy[j]};
        sb_q.push_back(e);
        en  = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
            en = 1'b0;
            if (lat == 1) chk("round_done_low", round_done, 0);
        end while (input_check !== 1'b1 && lat < 20);
        chk("fetch_latency", lat, 4);
        e = sb_q.pop_front();
        last_exp = e;
        chk($sformatf("x(%0d,%0d)", i, j),   x,   e.x);
        chk($sformatf("y(%0d,%0d)", i, j),   y,   e.y);
        chk($sformatf("vx(%0d,%0d)", i, j),  vx,  e.vx);
        chk($sformatf("vy(%0d,%0d)", i, j),  vy,  e.vy);
        chk($sformatf("x2(%0d,%0d)", i, j),  x2,  e.x2);
        chk($sformatf("y2(%0d,%0d)", i, j),  y2,  e.y2);
        chk($sformatf("vx2(%0d,%0d)", i, j), vx2, e.vx2);
        chk($sformatf("vy2(%0d,%0d)", i, j), vy2, e.vy2);
        tick();
        chk("input_check_pulse", input_check, 0);
        chk("busy_wait", busy, 1);
    endtask

    task automatic writeback(input int i, input int j,
                             input logic [W-1:0] a, b, c, d, input logic exp_rd);
        wb_vx1 = a; wb_vy1 = b; wb_vx2 = c; wb_vy2 = d;
        output_check = 1'b1;
        tick();
        output_check = 1'b0;
        tick();
        chk("busy_after_commit", busy, 0);
        chk("round_done", round_done, exp_rd);
        m_vx[i] = vclamp(a); m_vy[i] = vclamp(b);
        m_vx[j] = vclamp(c); m_vy[j] = vclamp(d);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{16'hFC00, 16'h0000, 16'h0400, 16'h0000, 0, 1, 1'b0};
        tbl[1] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 2, 1'b0};
        tbl[2] = '{16'h0500, 16'h0600, 16'h0700, 16'h0800, 0, 3, 1'b0};
        tbl[3] = '{16'h3000, 16'hC000, 16'h0900, 16'h0A00, 1, 2, 1'b0};
        tbl[4] = '{16'h0B00, 16'h0C00, 16'h0D00, 16'h0E00, 1, 3, 1'b0};
        tbl[5] = '{16'h0F00, 16'hF100, 16'hF200, 16'hF300, 2, 3, 1'b1};
        tbl[6] = '{16'h0123, 16'h0000, 16'h0456, 16'h0000, 0, 1, 1'b0};

        reset = 1'b1; en = 1'b0; output_check = 1'b0; ld_valid = 1'b0;
        ld_idx = '0; ld_data = '0;
        wb_vx1 = '0; wb_vy1 = '0; wb_vx2 = '0; wb_vy2 = '0;
        for (int b = 0; b < NB; b++) begin
            m_x[b] = '0; m_y[b] = '0; m_vx[b] = '0; m_vy[b] = '0;
        end
        tick();
        tick();
        reset = 1'b0;
        chk("rst_x", x, 0);
        chk("rst_vx2", vx2, 0);
        chk("rst_input_check", input_check, 0);
        chk("rst_busy", busy, 0);
        chk("rst_round_done", round_done, 0);

        preload(0, 16'h0800, 16'h0400, 16'h0400, 16'h0000);
        preload(1, 16'h1000, 16'h0400, 16'hFC00, 16'h0000);
        preload(2, 16'h1800, 16'h0C00, 16'h0200, 16'hFF00);
        preload(3, 16'h2000, 16'h1400, 16'hFE00, 16'h0100);

        // Full round plus wrap, with clamp-range write-backs in row 3.
        for (int r = 0; r < 7; r++) begin
            en = 1'b1;
            start_fetch(tbl[r].i, tbl[r].j);
            writeback(tbl[r].i, tbl[r].j, tbl[r].wvx1, tbl[r].wvy1,
                      tbl[r].wvx2, tbl[r].wvy2, tbl[r].rd);
        end

        // Preload during WAIT_WB leaves presented outputs alone; preload and
        // commit on the same bot in the same cycle: commit velocity wins.
        start_fetch(0, 2);
        preload(2, 16'h7000, 16'h7100, 16'h7200, 16'h7300);
        chk("hold_x2", x2, last_exp.x2);
        chk("hold_vx2", vx2, last_exp.vx2);
        wb_vx1 = 16'h0055; wb_vy1 = 16'h0066; wb_vx2 = 16'h0077; wb_vy2 = 16'h0088;
        output_check = 1'b1;
        tick();
        output_check = 1'b0;
        ld_valid = 1'b1; ld_idx = 2'd0;
        ld_data  = {16'h0111, 16'h0222, 16'h0333, 16'h0444};
        tick();
        ld_valid = 1'b0;
        chk("coll_busy", busy, 0);
        m_x[0] = 16'h0111; m_y[0] = 16'h0222;
        m_vx[0] = vclamp(16'h0055); m_vy[0] = vclamp(16'h0066);
        m_vx[2] = vclamp(16'h0077); m_vy[2] = vclamp(16'h0088);
        start_fetch(0, 3);
        writeback(0, 3, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 1'b0);

        // Strobe already high before PRESENT must not commit.
        output_check = 1'b1;
        tick();
        start_fetch(1, 2);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("held_high_no_commit", busy, 1);
        end
        output_check = 1'b0;
        tick();
        writeback(1, 2, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 1'b0);
        start_fetch(1, 3);
        writeback(1, 3, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b0);

        // Asynchronous reset in WAIT_WB.
        start_fetch(2, 3);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_x", x, 0);
        chk("arst_vy2", vy2, 0);
        chk("arst_input_check", input_check, 0);
        reset = 1'b0;
        for (int b = 0; b < NB; b++) begin
            m_x[b] = '0; m_y[b] = '0; m_vx[b] = '0; m_vy[b] = '0;
        end
        output_check = 1'b1;
        tick();
        tick();
        output_check = 1'b0;
        chk("arst_wb_discarded", busy, 0);
        start_fetch(0, 1);
        writeback(0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bot_state_server.md
# bot_state_server

Synthesizable responder for the integrator's state-fetch / velocity-write-back handshake. Holds position and velocity of every bot in Q5.11 fixed point, serves bot pairs (i, j) in fixed round-robin order when `en` is raised, and stores the post-collision velocities returned on `output_check`. It sits where the file-driven reader and writer sit in simulation, so the integrator loop runs on hardware without file I/O.

## Interface
- `N_BOTS`, default 4: number of bots; legal range 2..16.
- `W`, default 16: word width. Signed Q5.11 with 11 fraction bits.
- `VMAX`, default 16'sd4096 (+2.0): velocity clamp magnitude, used only with `VCLAMP_EN`.
- `clock` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `en` input 1: fetch request level; sampled only in IDLE.
- `x`, `y`, `vx`, `vy` output W: state of bot i.
- `x2`, `y2`, `vx2`, `vy2` output W: state of bot j.
- `input_check` output 1: one-cycle pulse; pair outputs valid.
- `output_check` input 1: write-back strobe; its rising edge is detected internally.
- `wb_vx1`, `wb_vy1`, `wb_vx2`, `wb_vy2` input W: new velocities for bot i and bot j.
- `ld_valid` input 1: preload strobe.
- `ld_idx` input $clog2(N_BOTS): preload bot index.
- `ld_data` input 4*W: preload record {x, y, vx, vy}, with x in the MSBs.
- `busy` output 1: high in every state except IDLE.
- `round_done` output 1: one-cycle pulse when the last pair's write-back completes.

## Operation
- Storage: register array of N_BOTS records {x, y, vx, vy}, reset to all zero.
- Pair counter (i, j) with i < j. Order is (0,1), (0,2) … (0,N-1), (1,2) … (N-2,N-1), then wrap to (0,1). Reset value is (0,1).
- FSM states: IDLE, RD_A, RD_B, PRESENT, WAIT_WB, COMMIT.
  - IDLE: if `en`=1, go to RD_A. Otherwise stay.
  - RD_A: latch record i into x/y/vx/vy registers. Go to RD_B.
  - RD_B: latch record j into x2/y2/vx2/vy2 registers. Go to PRESENT.
  - PRESENT: `input_check`=1 for this cycle only. Go to WAIT_WB.
  - WAIT_WB: hold all outputs. On an `output_check` 0→1 edge (previous-cycle sample 0, current 1), capture the four wb_* values and go to COMMIT. Any other level keeps waiting; there is no timeout.
  - COMMIT: write vx/vy of bot i and bot j, with clamping if enabled. Advance the pair counter. Pulse `round_done` if the pair was (N-2,N-1). Go to IDLE.
- `en` is ignored outside IDLE. Dropping `en` mid-fetch does not abort the fetch.
- `ld_valid` is accepted in any state and writes the full record in the same edge. Outputs already presented do not change.
- Collision rules for writes:
  - `ld_valid` and COMMIT target the same bot in the same cycle: the COMMIT velocity wins; the preload x/y are still written.
  - `ld_idx` ≥ N_BOTS: the preload is ignored.
- Position words are written only through preload.
- Arithmetic: no arithmetic except the optional clamp. Comparisons are signed W-bit.

## Timing
- Reset values: all pair outputs 0, `input_check`=0, `busy`=0, `round_done`=0, FSM in IDLE, edge detector's previous sample = 0.
- Fetch latency: `en` sampled high at edge k gives `input_check` high in the cycle after edge k+3. Pair outputs are stable from edge k+2 until the COMMIT edge.
- Write-back: `output_check` rising sampled at edge m gives the memory update at edge m+1 and IDLE after edge m+1. The next fetch starts no earlier than edge m+2.
- Minimum loop period is 6 cycles per pair.
- `reset` asserted mid-operation:
  - the FSM returns to IDLE immediately, without waiting for a clock edge;
  - the pair counter and memory are cleared;
  - a pending write-back is discarded.
- `output_check` already high on entry to WAIT_WB does not count as an edge; it must fall and rise again.

## Configuration
- `BOT_SERVER_VCLAMP_EN` defined: each written-back velocity is saturated to [-VMAX, +VMAX] before storage, with signed compare.
- Not defined: velocities are stored verbatim and the clamp logic is absent. `VMAX` is unused.

## Test plan
- Preload bot0={1.0, 0.5, 0.5, 0} (x=0x0800, y=0x0400, vx=0x0400, vy=0) and bot1={2.0, 0.5, -0.5, 0}, then hold `en`=1 → `input_check` pulses 4 cycles after the first `en` sample, with x=0x0800, vx2=0xFC00.
- Pulse `output_check` with wb_vx1=0xFC00, wb_vx2=0x0400 → the next fetch of pair (0,1) returns vx=0xFC00, vx2=0x0400.
- Run 6 pair fetch/write-back loops with N_BOTS=4 → pairs appear in order (0,1)…(2,3); `round_done` pulses once after (2,3); the 7th pair is (0,1).
- Write back wb_vx1=0x3000 (+6.0) → reads back 0x1000 with the macro defined, 0x3000 without it.
- Assert `reset` for 1 ns during WAIT_WB → `busy`=0 and outputs 0 immediately; the next fetch returns pair (0,1) with all-zero state.
- Keep `output_check` held high before PRESENT → no COMMIT occurs. A subsequent low-then-high commits exactly once.
